// File: rtl/hlsm_job_driver.sv
// hlsm_job_driver
// Initiator for the Start/Done handshake of a generated HLSM datapath block.
// Jobs {a, b, c, expected z, expected x} are buffered in a small FIFO and
// launched one at a time. Each result is checked against its expectation
// (or declared timed out), the HLSM is pulsed back to its wait state, and
// pass/fail/timeout statistics plus a sticky Error flag are maintained.
module hlsm_job_driver #(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 64,
  parameter int CNTW    = 16
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             JobValid,
  output logic             JobReady,
  input  logic [WIDTH-1:0] JobA,
  input  logic [WIDTH-1:0] JobB,
  input  logic [WIDTH-1:0] JobC,
  input  logic [WIDTH-1:0] ExpZ,
  input  logic [WIDTH-1:0] ExpX,
  output logic             DutRst,
  output logic             DutStart,
  output logic [WIDTH-1:0] DutA,
  output logic [WIDTH-1:0] DutB,
  output logic [WIDTH-1:0] DutC,
  input  logic             DutDone,
  input  logic [WIDTH-1:0] DutZ,
  input  logic [WIDTH-1:0] DutX,
  input  logic             ErrorRst,
  output logic             Error,
  output logic             Busy,
  output logic [CNTW-1:0]  PassCount,
  output logic [CNTW-1:0]  FailCount,
  output logic [CNTW-1:0]  TimeoutCount,
  output logic [CNTW-1:0]  LastLatency
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = 5 * WIDTH;
  localparam logic [CNTW-1:0] WAIT_LAST = CNTW'(TIMEOUT - 1);
  localparam logic [CNTW-1:0] CNT_MAX   = {CNTW{1'b1}};
  localparam logic [CNTW-1:0] CNT_ZERO  = {CNTW{1'b0}};
  localparam logic [AW:0]     OCC_FULL  = (AW + 1)'(DEPTH);
  localparam logic [AW:0]     OCC_ZERO  = {(AW + 1){1'b0}};
  localparam logic [WIDTH-1:0] DATA_ZERO = {WIDTH{1'b0}};

  typedef enum logic [2:0] {
    ST_INIT    = 3'd0,
    ST_IDLE    = 3'd1,
    ST_LAUNCH  = 3'd2,
    ST_WAIT    = 3'd3,
    ST_CHECK   = 3'd4,
    ST_RECOVER = 3'd5
  } state_t;

  state_t           state_r;

  // job FIFO
  logic [EW-1:0]    mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      occ_r;
  logic             empty_s;
  logic             full_s;
  logic             push_s;
  logic             pop_s;
  logic [EW-1:0]    head_s;

  // per-job context
  logic [WIDTH-1:0] exp_z_r;
  logic [WIDTH-1:0] exp_x_r;
  logic [WIDTH-1:0] res_z_r;
  logic [WIDTH-1:0] res_x_r;
  logic [CNTW-1:0]  wait_cnt_r;
  logic             match_s;
  logic             timeout_s;
  logic             error_set_s;

  // Saturating increment shared by all statistic counters.
  function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
    logic [CNTW-1:0] r;
    if (v == CNT_MAX) begin
      r = v;
    end else begin
      r = v + {{(CNTW - 1){1'b0}}, 1'b1};
    end
    return r;
  endfunction

  // Queue status, handshake decode and result classification.
  always_comb begin
    empty_s     = (occ_r == OCC_ZERO);
    full_s      = (occ_r == OCC_FULL);
    JobReady    = !full_s;
    push_s      = JobValid && !full_s;
    pop_s       = (state_r == ST_IDLE) && !empty_s;
    head_s      = mem_r[rd_ptr_r];
    Busy        = (state_r != ST_IDLE) || !empty_s;
    match_s     = (res_z_r == exp_z_r) && (res_x_r == exp_x_r);
    timeout_s   = (state_r == ST_WAIT) && !DutDone && (wait_cnt_r == WAIT_LAST);
    error_set_s = timeout_s || ((state_r == ST_CHECK) && !match_s);
  end

  // FIFO storage; contents need no reset because occupancy guards every read.
  always_ff @(posedge Clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= {JobA, JobB, JobC, ExpZ, ExpX};
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally modulo DEPTH.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      occ_r    <= OCC_ZERO;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + {{(AW - 1){1'b0}}, 1'b1};
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + {{(AW - 1){1'b0}}, 1'b1};
      end
      case ({push_s, pop_s})
        2'b10:   occ_r <= occ_r + {{AW{1'b0}}, 1'b1};
        2'b01:   occ_r <= occ_r - {{AW{1'b0}}, 1'b1};
        default: occ_r <= occ_r;
      endcase
    end
  end

  // Sticky Error: a new mismatch/timeout beats a simultaneous clear request.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      Error <= 1'b0;
    end else if (error_set_s) begin
      Error <= 1'b1;
    end else if (ErrorRst) begin
      Error <= 1'b0;
    end
  end

  // Job sequencer: launch, wait for Done or timeout, check, reset the HLSM.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_r      <= ST_INIT;
      DutRst       <= 1'b1;
      DutStart     <= 1'b0;
      DutA         <= DATA_ZERO;
      DutB         <= DATA_ZERO;
      DutC         <= DATA_ZERO;
      exp_z_r      <= DATA_ZERO;
      exp_x_r      <= DATA_ZERO;
      res_z_r      <= DATA_ZERO;
      res_x_r      <= DATA_ZERO;
      wait_cnt_r   <= CNT_ZERO;
      PassCount    <= CNT_ZERO;
      FailCount    <= CNT_ZERO;
      TimeoutCount <= CNT_ZERO;
      LastLatency  <= CNT_ZERO;
    end else begin
      case (state_r)
        ST_INIT: begin
          // DutRst has been high since reset; this cycle completes the pulse.
          DutRst  <= 1'b0;
          state_r <= ST_IDLE;
        end
        ST_IDLE: begin
          if (!empty_s) begin
            DutA     <= head_s[5*WIDTH-1:4*WIDTH];
            DutB     <= head_s[4*WIDTH-1:3*WIDTH];
            DutC     <= head_s[3*WIDTH-1:2*WIDTH];
            exp_z_r  <= head_s[2*WIDTH-1:WIDTH];
            exp_x_r  <= head_s[WIDTH-1:0];
            DutStart <= 1'b1;
            state_r  <= ST_LAUNCH;
          end
        end
        ST_LAUNCH: begin
          DutStart   <= 1'b0;
          wait_cnt_r <= CNT_ZERO;
          state_r    <= ST_WAIT;
        end
        ST_WAIT: begin
          if (DutDone) begin
            res_z_r     <= DutZ;
            res_x_r     <= DutX;
            LastLatency <= sat_inc(wait_cnt_r);
            state_r     <= ST_CHECK;
          end else if (wait_cnt_r == WAIT_LAST) begin
            TimeoutCount <= sat_inc(TimeoutCount);
            DutRst       <= 1'b1;
            state_r      <= ST_RECOVER;
          end else begin
            wait_cnt_r <= sat_inc(wait_cnt_r);
          end
        end
        ST_CHECK: begin
          if (match_s) begin
            PassCount <= sat_inc(PassCount);
          end else begin
            FailCount <= sat_inc(FailCount);
          end
          DutRst  <= 1'b1;
          state_r <= ST_RECOVER;
        end
        ST_RECOVER: begin
          DutRst  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          // Unreachable encoding: re-initialise the HLSM and start over.
          DutRst   <= 1'b1;
          DutStart <= 1'b0;
          state_r  <= ST_INIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hlsm_job_driver.sv
// tb_hlsm_job_driver
// Random and directed jobs are pushed into hlsm_job_driver. A behavioural HLSM
// responder answers each Start after a planned latency (or never). At push time
// the reference model decides whether the job will pass, fail or time out and
// queues that expectation; a negedge monitor pops it when the job launches and
// checks counters, latency, job duration and the sticky Error flag.
module tb_hlsm_job_driver;

  localparam int WIDTH   = 32;
  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 8;
  localparam int CNTW    = 16;
  localparam int NEVER   = 1000;

  logic             Clk = 1'b0;
  logic             Rst = 1'b1;
  logic             JobValid = 1'b0;
  logic             JobReady;
  logic [WIDTH-1:0] JobA = '0, JobB = '0, JobC = '0, ExpZ = '0, ExpX = '0;
  logic             DutRst, DutStart;
  logic [WIDTH-1:0] DutA, DutB, DutC;
  logic             DutDone = 1'b0;
  logic [WIDTH-1:0] DutZ = '0, DutX = '0;
  logic             ErrorRst = 1'b0;
  logic             Error, Busy;
  logic [CNTW-1:0]  PassCount, FailCount, TimeoutCount, LastLatency;

  hlsm_job_driver #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .CNTW(CNTW)) dut (
    .Clk(Clk), .Rst(Rst), .JobValid(JobValid), .JobReady(JobReady),
    .JobA(JobA), .JobB(JobB), .JobC(JobC), .ExpZ(ExpZ), .ExpX(ExpX),
    .DutRst(DutRst), .DutStart(DutStart), .DutA(DutA), .DutB(DutB), .DutC(DutC),
    .DutDone(DutDone), .DutZ(DutZ), .DutX(DutX), .ErrorRst(ErrorRst),
    .Error(Error), .Busy(Busy), .PassCount(PassCount), .FailCount(FailCount),
    .TimeoutCount(TimeoutCount), .LastLatency(LastLatency)
  );

  always #5 Clk = ~Clk;

  typedef struct { logic [31:0] a, b, c; int kind; int lat; } exp_t;  // kind: 0 pass, 1 fail, 2 timeout
  typedef struct { int lat; bit fault; } plan_t;

  exp_t  exp_q[$];
  plan_t plan_q[$];
  int    vectors = 0;
  int    miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // The HLSM function the responder implements.
  function automatic logic [31:0] hlsm_z(input logic [31:0] a, b, c);
    return a * c + b;
  endfunction
  function automatic logic [31:0] hlsm_x(input logic [31:0] a, b);
    return a - b;
  endfunction

  // ---------------- HLSM responder ----------------
  bit rsp_busy = 0;
  int rsp_cnt = 0;
  plan_t rsp_p;
  always @(negedge Clk) begin
    DutDone = 1'b0;
    DutZ = $urandom;
    DutX = $urandom;
    if (DutRst) begin
      rsp_busy = 0;
    end else if (DutStart) begin
      if (plan_q.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL responder_plan: got start with no planned job (t=%0t)", $time);
      end else begin
        rsp_p = plan_q.pop_front();
        rsp_busy = 1;
        rsp_cnt = 0;
      end
    end else if (rsp_busy) begin
      rsp_cnt++;
      if (rsp_cnt == rsp_p.lat) begin
        DutDone = 1'b1;
        DutZ = hlsm_z(DutA, DutB, DutC) + (rsp_p.fault ? 32'd1 : 32'd0);
        DutX = hlsm_x(DutA, DutB);
        rsp_busy = 0;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  bit rst_prev = 1, erst_prev = 0, in_flight = 0, recover_prev = 0, exp_err = 0, post_set;
  logic [CNTW-1:0] m_pass = '0, m_fail = '0, m_to = '0, m_lat = '0;
  exp_t cur;
  int fl_cycles = 0;
  always @(negedge Clk) begin
    if (rst_prev) begin
      exp_q.delete(); plan_q.delete();
      in_flight = 0; recover_prev = 0; exp_err = 0;
      m_pass = '0; m_fail = '0; m_to = '0; m_lat = '0;
      check("rst_dutrst", DutRst, 1);
      check("rst_dutstart", DutStart, 0);
      check("rst_duta", DutA, 0);
      check("rst_error", Error, 0);
      check("rst_pass", PassCount, 0);
      check("rst_fail", FailCount, 0);
      check("rst_timeout", TimeoutCount, 0);
      check("rst_latency", LastLatency, 0);
    end else begin
      if (recover_prev) check("dutrst_one_cycle", DutRst, 0);
      recover_prev = 0;
      post_set = 0;
      if (in_flight) begin
        fl_cycles++;
        if (DutRst) begin
          case (cur.kind)
            0: begin m_pass++; m_lat = cur.lat[CNTW-1:0]; end
            1: begin m_fail++; m_lat = cur.lat[CNTW-1:0]; post_set = 1; end
            default: begin m_to++; post_set = 1; end
          endcase
          check("pass_count", PassCount, m_pass);
          check("fail_count", FailCount, m_fail);
          check("timeout_count", TimeoutCount, m_to);
          check("last_latency", LastLatency, m_lat);
          check("job_duration", fl_cycles, (cur.kind == 2) ? TIMEOUT + 1 : cur.lat + 2);
          check("operands_stable", {DutA, DutB ^ DutC}, {cur.a, cur.b ^ cur.c});
          in_flight = 0;
          recover_prev = 1;
        end else if (fl_cycles > TIMEOUT + 4) begin
          vectors++; miscompares++;
          $display("FAIL job_watchdog: job still running after %0d cycles (t=%0t)", fl_cycles, $time);
          in_flight = 0;
        end
      end
      if (post_set) exp_err = 1;
      else if (erst_prev) exp_err = 0;
      if (DutStart) begin
        check("start_while_busy", in_flight, 0);
        if (exp_q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL unexpected_start: DutStart with no job expected (t=%0t)", $time);
        end else begin
          cur = exp_q.pop_front();
          check("launch_a", DutA, cur.a);
          check("launch_b", DutB, cur.b);
          check("launch_c", DutC, cur.c);
          in_flight = 1;
          fl_cycles = 0;
        end
      end
      check("error_flag", Error, exp_err);
    end
    rst_prev = Rst;
    erst_prev = ErrorRst;
  end

  // ---------------- stimulus helpers ----------------
  // Leaves the caller at 1 time unit after a rising edge.
  task automatic cyc(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic push_job(input logic [31:0] a, b, c, ez, ex, input int lat, input bit fault);
    int guard = 0;
    exp_t e;
    plan_t p;
    logic [31:0] hz, hx;
    JobValid = 1'b1; JobA = a; JobB = b; JobC = c; ExpZ = ez; ExpX = ex;
    @(negedge Clk);
    while (!JobReady && guard < 300) begin guard++; @(negedge Clk); end
    if (!JobReady) begin
      vectors++; miscompares++;
      $display("FAIL push_timeout: JobReady stayed 0 (t=%0t)", $time);
      @(posedge Clk); #1 JobValid = 1'b0;
      return;
    end
    @(posedge Clk);
    hz = hlsm_z(a, b, c) + (fault ? 32'd1 : 32'd0);
    hx = hlsm_x(a, b);
    e.a = a; e.b = b; e.c = c; e.lat = lat;
    e.kind = (lat > TIMEOUT) ? 2 : ((hz == ez && hx == ex) ? 0 : 1);
    p.lat = lat; p.fault = fault;
    exp_q.push_back(e);
    plan_q.push_back(p);
    #1 JobValid = 1'b0;
  endtask

  task automatic good_job(input int lat);
    logic [31:0] a, b, c;
    a = $urandom; b = $urandom; c = $urandom;
    push_job(a, b, c, hlsm_z(a, b, c), hlsm_x(a, b), lat, 1'b0);
  endtask

  task automatic wait_idle();
    int guard = 0;
    @(negedge Clk);
    while ((exp_q.size() != 0 || in_flight || Busy) && guard < 3000) begin guard++; @(negedge Clk); end
    if (guard >= 3000) begin
      vectors++; miscompares++;
      $display("FAIL wait_idle: driver never went idle (t=%0t)", $time);
    end
    cyc(1);
  endtask

  // Call right after deasserting Rst at 1 unit past an edge.
  task automatic after_reset_checks();
    @(negedge Clk);
    check("init_dutrst", DutRst, 1);
    check("init_jobready", JobReady, 1);
    @(negedge Clk);
    check("idle_dutrst", DutRst, 0);
    check("idle_busy", Busy, 0);
    cyc(1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] a, b, c, ez, ex;
    int g;
    Rst = 1'b1;
    cyc(3);
    Rst = 1'b0;
    after_reset_checks();

    // correct result
    push_job(32'd3, 32'd5, 32'd2, 32'd11, 32'hFFFF_FFFE, 4, 1'b0);
    wait_idle();
    check("t1_pass", PassCount, 1);
    check("t1_latency", LastLatency, 4);
    check("t1_error", Error, 0);

    // mismatch: HLSM returns z = 12
    push_job(32'd3, 32'd5, 32'd2, 32'd11, 32'hFFFF_FFFE, 4, 1'b1);
    wait_idle();
    check("t2_fail", FailCount, 1);
    check("t2_error", Error, 1);
    ErrorRst = 1'b1; cyc(1); ErrorRst = 1'b0;
    check("t2_error_cleared", Error, 0);
    check("t2_fail_kept", FailCount, 1);

    // timeout, then a good job, boundary latency of exactly TIMEOUT
    good_job(NEVER);
    wait_idle();
    check("t3_timeout", TimeoutCount, 1);
    check("t3_error", Error, 1);
    good_job(TIMEOUT);
    wait_idle();
    check("t3_pass_after", PassCount, 2);
    check("t3_latency", LastLatency, TIMEOUT);
    ErrorRst = 1'b1; cyc(1); ErrorRst = 1'b0;

    // queue full and wrap: first job stalls for the full window
    good_job(TIMEOUT);
    for (int i = 0; i < 8; i++) good_job($urandom_range(1, TIMEOUT));
    check("t4_full_ready", JobReady, 0);
    check("t4_busy", Busy, 1);
    wait_idle();
    check("t4_pass", PassCount, 11);
    check("t4_ready_again", JobReady, 1);

    // ErrorRst held across a mismatching job: set must win at CHECK
    ErrorRst = 1'b1;
    good_job(2);
    a = 32'd7; b = 32'd1; c = 32'd9;
    push_job(a, b, c, hlsm_z(a, b, c), hlsm_x(a, b), 2, 1'b1);
    wait_idle();
    ErrorRst = 1'b0;
    check("t5_fail", FailCount, 2);

    // push coinciding with the IDLE pop
    good_job(1);
    good_job(1);
    wait_idle();
    check("t6_pass", PassCount, 14);
    check("t6_latency", LastLatency, 1);

    // randomized jobs
    for (int i = 0; i < 40; i++) begin
      cyc($urandom_range(0, 3));
      a = $urandom; b = $urandom; c = $urandom;
      ez = hlsm_z(a, b, c); ex = hlsm_x(a, b);
      if ($urandom_range(0, 4) == 0) ez = ez ^ (32'd1 << $urandom_range(0, 31));
      if ($urandom_range(0, 4) == 0) ex = ex ^ (32'd1 << $urandom_range(0, 31));
      ErrorRst = ($urandom_range(0, 5) == 0);
      push_job(a, b, c, ez, ex,
               ($urandom_range(0, 5) == 0) ? NEVER : $urandom_range(1, TIMEOUT),
               ($urandom_range(0, 3) == 0));
    end
    wait_idle();
    ErrorRst = 1'b0;

    // reset mid-WAIT with three jobs queued
    for (int i = 0; i < 4; i++) good_job(NEVER);
    g = 0;
    @(negedge Clk);
    while (!DutStart && g < 100) begin g++; @(negedge Clk); end
    check("t8_started", DutStart, 1);
    @(negedge Clk); @(negedge Clk);
    cyc(1);
    Rst = 1'b1;
    cyc(2);
    Rst = 1'b0;
    after_reset_checks();
    check("t8_pass_zero", PassCount, 0);
    check("t8_timeout_zero", TimeoutCount, 0);
    good_job(5);
    wait_idle();
    check("t8_pass_after", PassCount, 1);
    check("t8_latency_after", LastLatency, 5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #300000;
    miscompares++;
    $display("FAIL global_timeout: simulation did not complete");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hlsm_job_driver.md
Name: hlsm_job_driver

Overview:
- Initiator side of the Start/Done handshake used by our generated HLSM datapath blocks (inputs a, b, c; outputs z, x).
- Accepts operand jobs with expected results into a small queue and launches each job into the HLSM (Start pulse, operands held stable).
- Waits for Done with a timeout, then compares z and x against the expected values.
- Pulses the HLSM reset so it returns to its wait state, and keeps pass/fail/timeout statistics plus a sticky Error.
- Sits between a host/bench job source and one HLSM instance.

Parameters:
- WIDTH, 32, operand/result width.
- DEPTH, 8, job queue entries (power of 2, >=2).
- TIMEOUT, 64, max WAIT cycles before a job is declared timed out (>=2).
- CNTW, 16, width of the statistic counters.

Ports:
- Clk  in  1  clock.
- Rst  in  1  reset, synchronous, active-high.
- JobValid  in  1  job offered.
- JobReady  out  1  queue can accept; equals !full.
- JobA, JobB, JobC  in  WIDTH  operands.
- ExpZ, ExpX  in  WIDTH  expected results.
- DutRst  out  1  reset to the HLSM.
- DutStart  out  1  Start to the HLSM.
- DutA, DutB, DutC  out  WIDTH  operands to the HLSM.
- DutDone  in  1  HLSM finished.
- DutZ, DutX  in  WIDTH  HLSM results.
- ErrorRst  in  1  clears Error.
- Error  out  1  sticky mismatch/timeout flag.
- Busy  out  1  FSM not in IDLE, or queue not empty.
- PassCount, FailCount, TimeoutCount  out  CNTW  statistics.
- LastLatency  out  CNTW  cycles from DutStart to DutDone of the last passed or failed job.

Behaviour:
- Reset:
  - FSM enters INIT.
  - Queue empty; all counters and LastLatency = 0.
  - Error = 0, DutStart = 0, DutA/B/C = 0.
  - DutRst = 1 while Rst is high.
  - Reset mid-job aborts the job, discards all queued jobs and updates no counters.
- Queue:
  - A push occurs when JobValid && JobReady; the job is the 5-tuple {JobA, JobB, JobC, ExpZ, ExpX}.
  - A pop occurs only on the IDLE->LAUNCH transition.
  - A push and a pop in the same cycle are both performed; occupancy is unchanged.
  - Pointers wrap modulo DEPTH. A push when full is impossible because JobReady = 0.
- FSM states and transitions:
  - INIT: DutRst = 1 for one cycle -> IDLE.
  - IDLE: if the queue is non-empty, pop, latch operands to DutA/B/C and expected values internally -> LAUNCH; else stay.
  - LAUNCH: DutStart = 1 for exactly this one cycle; clear the wait counter -> WAIT.
  - WAIT:
    - Wait counter increments each cycle.
    - If DutDone = 1: capture DutZ/DutX, set LastLatency = wait counter + 1 -> CHECK.
    - Else, if wait counter == TIMEOUT-1: TimeoutCount++, set Error -> RECOVER.
    - DutDone is ignored in every other state.
  - CHECK: if captured Z == ExpZ and captured X == ExpX, PassCount++; else FailCount++ and set Error -> RECOVER.
  - RECOVER: DutRst = 1 for one cycle -> IDLE.
- Timing:
  - Earliest next DutStart is 3 cycles after RECOVER (RECOVER, IDLE, LAUNCH).
  - Minimum job period is 5 cycles, with DutDone in the first WAIT cycle.
- Operands: DutA/B/C change only on IDLE->LAUNCH and are stable through LAUNCH, WAIT, CHECK and RECOVER.
- Arithmetic:
  - Comparison is exact over all WIDTH bits.
  - Counters saturate at 2^CNTW-1; they do not wrap.
  - The wait counter is CNTW bits wide.
- Error:
  - Error is set by a mismatch or a timeout and cleared by ErrorRst.
  - If a set and ErrorRst occur in the same cycle, set wins.
  - ErrorRst does not affect the counters or the FSM.
- Outputs are registered except JobReady and Busy (combinational from registered state).

Test Plan:
- Correct result: push (a=3, b=5, c=2, ExpZ=11, ExpX=-2 i.e. 0xFFFFFFFE); model answers DutDone 4 cycles after DutStart with z=11, x=0xFFFFFFFE.
  -> PassCount=1, LastLatency=4, Error=0, one DutRst pulse after CHECK.
- Mismatch: same job, model returns z=12.
  -> FailCount=1, Error=1. Then ErrorRst=1 -> Error=0, FailCount stays 1.
- Timeout: TIMEOUT=8, model never asserts DutDone.
  -> exactly 8 WAIT cycles, TimeoutCount=1, Error=1, DutRst pulse, return to IDLE.
  -> A subsequent good job still passes.
- Queue full and wrap: stall DutDone, push 9 jobs with DEPTH=8.
  -> JobReady drops after the 8th push is accepted while the first job is in flight.
  -> Release the model: all 9 complete in order, PassCount=9, pointers wrap correctly.
- Simultaneous events:
  - ErrorRst asserted in the same cycle as a CHECK mismatch -> Error=1.
  - Push during the IDLE pop cycle -> occupancy unchanged, both jobs processed.
- Reset mid-WAIT with 3 jobs queued:
  -> counters=0, queue empty, DutRst=1 during Rst and for the INIT cycle, then IDLE with Busy=0.
